// File: rtl/exc_cp0.sv
// CP0 exception/interrupt controller: SR, Cause, EPC and PrID, plus the
// zero-latency IntReq that flushes the pipeline and redirects to the handler.
module exc_cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [31:0] pc_nxt,
    input  logic [6:2]  exc_code_m,
    input  logic        bd_m,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic        eret_m,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        int_req,
    output logic [31:0] epc,
    output logic        exl,
    output logic [31:0] handler_pc
);

    localparam logic [31:0] PRID_C    = 32'h4C4F_5249;
    localparam logic [31:0] HANDLER_C = 32'h0000_4180;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;

    logic        irq_s, exc_s, int_req_s;
    logic [31:0] base_s, sr_s, cause_s;

    // Request decode; a bubble in M borrows the PC of the next younger instruction.
    always_comb begin
        irq_s     = (|(hw_int & im_q)) & ie_q & ~exl_q;
        exc_s     = (exc_code_m != 5'd0) & ~exl_q;
        int_req_s = irq_s | exc_s;
        if (pc_m != 32'd0) begin
            base_s = pc_m;
        end else begin
            base_s = pc_nxt;
        end
    end

    // Next-state: taking an interrupt/exception overrides mtc0 and eret; eret beats an SR write of EXL.
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        if (int_req_s) begin
            exl_d = 1'b1;
            bd_d  = bd_m;
            if (irq_s) begin
                code_d = 5'd0;
            end else begin
                code_d = exc_code_m;
            end
            if (bd_m) begin
                epc_d = base_s - 32'd4;
            end else begin
                epc_d = base_s;
            end
        end else begin
            if (we) begin
                case (addr)
                    5'd12: begin
                        im_d  = din[15:10];
                        exl_d = din[1];
                        ie_d  = din[0];
                    end
                    5'd14:   epc_d = din & 32'hFFFF_FFFC;
                    default: epc_d = epc_q;
                endcase
            end else begin
                epc_d = epc_q;
            end
            if (eret_m) begin
                exl_d = 1'b0;
            end else begin
                bd_d = bd_q;
            end
        end
    end

    // State registers; Cause.IP samples the interrupt lines on every non-reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q   <= 6'd0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= 6'd0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= hw_int;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    // mfc0 read mux from pre-edge state.
    always_comb begin
        sr_s    = {16'd0, im_q, 8'd0, exl_q, ie_q};
        cause_s = {bd_q, 15'd0, ip_q, 3'd0, code_q, 2'd0};
        case (addr)
            5'd12:   dout = sr_s;
            5'd13:   dout = cause_s;
            5'd14:   dout = epc_q;
            5'd15:   dout = PRID_C;
            default: dout = 32'd0;
        endcase
    end

    assign int_req    = int_req_s;
    assign epc        = epc_q;
    assign exl        = exl_q;
    assign handler_pc = HANDLER_C;

endmodule

// File: tb/tb_exc_cp0.sv
// Directed bench for exc_cp0: a word-level CP0 model checked every cycle, plus literal spot checks.
module tb_exc_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m, pc_nxt, din;
    logic [4:0]  exc_code_m, addr;
    logic        bd_m, we, eret_m;
    logic [5:0]  hw_int;
    logic [31:0] dout, epc, handler_pc;
    logic        int_req, exl;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // Model state as whole architectural register words
    logic [31:0] m_sr, m_cause, m_epc;

    exc_cp0 dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .pc_nxt(pc_nxt),
        .exc_code_m(exc_code_m), .bd_m(bd_m), .hw_int(hw_int), .we(we),
        .eret_m(eret_m), .addr(addr), .din(din), .dout(dout),
        .int_req(int_req), .epc(epc), .exl(exl), .handler_pc(handler_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_irq();
        return (|(hw_int & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_irq() | ((exc_code_m != 5'd0) & ~m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h4C4F_5249;
            default: return 32'd0;
        endcase
    endfunction

    // Model update at each edge from the architectural rules
    always @(posedge clk) begin
        logic [31:0] ns, nc, ne, base;
        ns = m_sr; nc = m_cause; ne = m_epc;
        if (reset) begin
            ns = 32'd0; nc = 32'd0; ne = 32'd0;
        end else begin
            nc[15:10] = hw_int;
            if (m_req()) begin
                base = (pc_m != 32'd0) ? pc_m : pc_nxt;
                ns[1] = 1'b1;
                nc[31] = bd_m;
                nc[6:2] = m_irq() ? 5'd0 : exc_code_m;
                ne = bd_m ? base - 32'd4 : base;
            end else begin
                if (we && addr == 5'd12) ns = din & 32'h0000_FC03;
                if (we && addr == 5'd14) ne = {din[31:2], 2'b00};
                if (eret_m) ns[1] = 1'b0;
            end
        end
        m_sr <= ns; m_cause <= nc; m_epc <= ne;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("int_req", {31'd0, int_req}, {31'd0, m_req()});
            chk("exl", {31'd0, exl}, {31'd0, m_sr[1]});
            chk("epc", epc, m_epc);
            chk("dout", dout, m_read(addr));
            chk("handler_pc", handler_pc, 32'h0000_4180);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; eret_m = 1'b0; exc_code_m = 5'd0; bd_m = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pc_m = 32'd0; pc_nxt = 32'd0; din = 32'd0; addr = 5'd0;
        hw_int = 6'd0; idle();
        tick(); tick();
        chk_en = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_epc", epc, 32'd0);
        chk("rst_exl", {31'd0, exl}, 32'd0);
        chk("rst_int_req", {31'd0, int_req}, 32'd0);

        // Interrupt
        we = 1'b1; addr = 5'd12; din = 32'h0000_0401; tick();
        we = 1'b0; hw_int = 6'b000001; pc_m = 32'h3008; #1;
        chk("irq_req", {31'd0, int_req}, 32'd1);
        tick();
        addr = 5'd13; #1;
        chk("irq_exl", {31'd0, exl}, 32'd1);
        chk("irq_cause", dout, 32'h0000_0400);
        chk("irq_epc", epc, 32'h3008);
        chk("irq_drop", {31'd0, int_req}, 32'd0);

        // Exception in delay slot
        hw_int = 6'd0; eret_m = 1'b1; tick(); idle();
        we = 1'b1; addr = 5'd12; din = 32'd0; tick(); idle();
        exc_code_m = 5'd4; bd_m = 1'b1; pc_m = 32'h3010; #1;
        chk("exc_req", {31'd0, int_req}, 32'd1);
        tick(); idle(); addr = 5'd13; #1;
        chk("exc_cause", dout, 32'h8000_0010);
        chk("exc_epc", epc, 32'h300C);

        // Bubble interrupt
        eret_m = 1'b1; tick(); idle();
        we = 1'b1; addr = 5'd12; din = 32'h0000_0401; tick(); idle();
        pc_m = 32'd0; pc_nxt = 32'h3020; hw_int = 6'b000001; tick();
        chk("bub_epc", epc, 32'h3020);

        // Masking while EXL, then eret reopens
        we = 1'b1; addr = 5'd12; din = 32'h0000_FC03; hw_int = 6'h3F; tick(); idle();
        #1 chk("mask_req", {31'd0, int_req}, 32'd0);
        eret_m = 1'b1; tick(); idle();
        chk("eret_exl", {31'd0, exl}, 32'd0);
        chk("eret_req", {31'd0, int_req}, 32'd1);
        tick();
        hw_int = 6'd0; eret_m = 1'b1; tick(); idle();

        // mtc0 EPC collision then solo write
        exc_code_m = 5'd10; pc_m = 32'h3040; we = 1'b1; addr = 5'd14; din = 32'h1234_5677;
        tick(); idle();
        chk("coll_epc", epc, 32'h3040);
        eret_m = 1'b1; tick(); idle();
        we = 1'b1; addr = 5'd14; din = 32'h1234_5677; tick(); idle();
        chk("wr_epc", epc, 32'h1234_5674);

        // Reads and ignored Cause write
        addr = 5'd15; #1 chk("prid", dout, 32'h4C4F_5249);
        addr = 5'd7;  #1 chk("unmapped", dout, 32'd0);
        we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF; tick(); idle();
        chk("cause_ro", dout, 32'h0000_0028);

        // eret vs SR write of EXL
        we = 1'b1; addr = 5'd12; din = 32'h0000_FC03; tick(); idle();
        we = 1'b1; eret_m = 1'b1; din = 32'h0000_8403; tick(); idle();
        chk("we_eret_sr", dout, 32'h0000_8401);
        chk("we_eret_exl", {31'd0, exl}, 32'd0);

        // Reset mid-handler beats everything
        we = 1'b1; din = 32'h0000_FC03; tick(); idle();
        reset = 1'b1; hw_int = 6'h3F; we = 1'b1; eret_m = 1'b1; exc_code_m = 5'd8; tick();
        reset = 1'b0; idle(); #1;
        chk("rst2_exl", {31'd0, exl}, 32'd0);
        chk("rst2_epc", epc, 32'd0);
        chk("rst2_sr", dout, 32'd0);
        chk("rst2_req", {31'd0, int_req}, 32'd0);
        tick(); tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
